// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the message-level UART transmit arbiter.
package uart_arb_pkg;

    localparam int UART_ARB_MAX_N = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        ISSUE,
        BUSY
    } arb_state_t;

    // Round-robin successor of idx in a ring of n slots.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr wins.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          any
);

    logic found;
    int   idx;

    always_comb begin
        win   = '0;
        any   = |req;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Locks one uart_tx to a single requester per message, round-robin between messages.
// Optional stall timeout is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N              = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   grant,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic           timeout
);

    localparam int PW = $clog2(N);

    if (N < 2 || N > UART_ARB_MAX_N || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported N or TIMEOUT_CYCLES");
    end

    arb_state_t    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] g_idx;
    logic          last_q;
    logic [N-1:0]  win;
    logic          any;
    logic [PW-1:0] win_idx;
    logic          xfer;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .win (win),
        .any (any)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++)
            if (win[i]) win_idx = PW'(i);
    end

    // req_ready is only ever set for the owner, so this is the owner's handshake.
    assign xfer = |(req_valid & req_ready);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] stall_cnt;
    logic          timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            g_idx     <= '0;
            last_q    <= 1'b0;
            grant     <= '0;
            req_ready <= '0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            tx_valid <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any) begin
                        grant     <= win;
                        req_ready <= win;
                        g_idx     <= win_idx;
                        state     <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (xfer) begin
                        tx_data   <= req_data[8*g_idx +: 8];
                        last_q    <= req_last[g_idx];
                        req_ready <= '0;
                        state     <= ISSUE;
`ifdef UART_ARB_TIMEOUT_EN
                        stall_cnt <= '0;
`endif
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    // Silent owner: drop the lock as if its last byte had gone out.
                    else if (stall_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        req_ready <= '0;
                        grant     <= '0;
                        ptr       <= PW'(rr_next(int'(g_idx), N));
                        stall_cnt <= '0;
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
`endif
                end
                ISSUE: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // Wait for the UART to take the byte so it is never issued twice.
                    if (!tx_ready) begin
                        if (last_q) begin
                            grant <= '0;
                            ptr   <= PW'(rr_next(int'(g_idx), N));
                            state <= IDLE;
                        end else begin
                            req_ready <= grant;
                            state     <= ACCEPT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with requester sources and a simple uart_tx model.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timeout;

    uart_tx_arbiter #(.N(4), .TIMEOUT_CYCLES(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] s_data [4][8];
    logic       s_last [4][8];
    int         s_len  [4];
    int         s_pos  [4];
    bit         s_en   [4];
    bit         s_pend [4];
    int         uart_cnt;
    logic [3:0] prev_grant;
    logic [7:0] tx_log_d [$];
    logic [3:0] tx_log_g [$];
    logic [3:0] g_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = s_en[i] && (s_pos[i] < s_len[i]);
            req_data[8*i +: 8] = 8'h00;
            req_last[i] = 1'b0;
            if (req_valid[i]) begin
                req_data[8*i +: 8] = s_data[i][s_pos[i]];
                req_last[i] = s_last[i][s_pos[i]];
            end
            s_pend[i] = req_valid[i] && req_ready[i];
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 4; i++) begin
            s_len[i] = 0; s_pos[i] = 0; s_en[i] = 1'b0; s_pend[i] = 1'b0;
        end
        uart_cnt = 0;
        tx_ready = 1'b1;
        prev_grant = 4'h0;
        tx_log_d.delete();
        tx_log_g.delete();
        g_log.delete();
        drive_srcs();
    endtask

    task automatic put(input int i, input logic [7:0] d, input logic l);
        s_data[i][s_len[i]] = d;
        s_last[i][s_len[i]] = l;
        s_len[i]++;
    endtask

    // One cycle: observe at the falling edge, then advance the models.
    task automatic step();
        @(negedge clk);
        chk("grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
        chk("ready_outside_grant", {28'd0, req_ready & ~grant}, 32'd0);
        if (tx_valid) begin
            chk("issue_while_uart_busy", {31'd0, tx_ready}, 32'd1);
            tx_log_d.push_back(tx_data);
            tx_log_g.push_back(grant);
            uart_cnt = 10;
            tx_ready = 1'b0;
        end else if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) tx_ready = 1'b1;
        end
        if (grant != 4'h0 && prev_grant == 4'h0) g_log.push_back(grant);
        prev_grant = grant;
        for (int i = 0; i < 4; i++)
            if (s_pend[i]) s_pos[i]++;
        drive_srcs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_models();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_tx(input int n, input int bound);
        int k = 0;
        while (tx_log_d.size() < n && k < bound) begin step(); k++; end
        chk("wait_tx_bound", {31'd0, tx_log_d.size() >= n}, 32'd1);
    endtask

    task automatic wait_done(input int n, input int bound);
        int k = 0;
        while (!(tx_log_d.size() >= n && grant == 4'h0) && k < bound) begin step(); k++; end
        chk("wait_done_bound", {31'd0, tx_log_d.size() >= n && grant == 4'h0}, 32'd1);
    endtask

    initial begin
        logic [7:0] exp_d [4];
        logic [3:0] exp_g [6];
        int k;

        rst_n = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        clear_models();

        // Reset state
        step(); step();
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        rst_n = 1'b1;

        // Single requester 2 sends "Hi\n"
        do_reset();
        put(2, 8'h48, 1'b0); put(2, 8'h69, 1'b0); put(2, 8'h0A, 1'b1);
        s_en[2] = 1'b1;
        drive_srcs();
        step();
        chk("single_ready_lat", {28'd0, req_ready}, 32'h4);
        chk("single_grant", {28'd0, grant}, 32'h4);
        step();
        chk("single_no_early_valid", {31'd0, tx_valid}, 32'd0);
        step();
        chk("single_valid_lat", {31'd0, tx_valid}, 32'd1);
        chk("single_first_byte", {24'd0, tx_data}, 32'h48);
        wait_done(3, 300);
        repeat (30) step();
        chk("single_count", tx_log_d.size(), 32'd3);
        exp_d[0] = 8'h48; exp_d[1] = 8'h69; exp_d[2] = 8'h0A;
        for (int i = 0; i < 3; i++) begin
            chk("single_data", {24'd0, tx_log_d[i]}, {24'd0, exp_d[i]});
            chk("single_owner", {28'd0, tx_log_g[i]}, 32'h4);
        end
        chk("single_release", {28'd0, grant}, 32'd0);

        // Contention: 0 and 1 both valid at reset release
        rst_n = 1'b0;
        clear_models();
        put(0, 8'hA0, 1'b0); put(0, 8'hA1, 1'b1);
        put(1, 8'hB0, 1'b0); put(1, 8'hB1, 1'b1);
        s_en[0] = 1'b1; s_en[1] = 1'b1;
        step(); step();
        rst_n = 1'b1;
        wait_done(4, 400);
        exp_d[0] = 8'hA0; exp_d[1] = 8'hA1; exp_d[2] = 8'hB0; exp_d[3] = 8'hB1;
        for (int i = 0; i < 4; i++) begin
            chk("contend_data", {24'd0, tx_log_d[i]}, {24'd0, exp_d[i]});
            chk("contend_owner", {28'd0, tx_log_g[i]}, (i < 2) ? 32'h1 : 32'h2);
        end

        // Fairness: all four always valid with one-byte messages
        do_reset();
        for (int i = 0; i < 4; i++) begin
            put(i, 8'(8'h10 * i), 1'b1);
            put(i, 8'(8'h10 * i + 1), 1'b1);
            s_en[i] = 1'b1;
        end
        drive_srcs();
        wait_done(8, 800);
        exp_g[0] = 4'h1; exp_g[1] = 4'h2; exp_g[2] = 4'h4;
        exp_g[3] = 4'h8; exp_g[4] = 4'h1; exp_g[5] = 4'h2;
        for (int i = 0; i < 6; i++)
            chk("fair_order", {28'd0, g_log[i]}, {28'd0, exp_g[i]});
        chk("fair_first_byte", {24'd0, tx_log_d[0]}, 32'h00);
        chk("fair_second_byte", {24'd0, tx_log_d[1]}, 32'h10);

`ifndef UART_ARB_TIMEOUT_EN
        // Stall: owner goes quiet mid-message while 3 waits
        do_reset();
        put(0, 8'hC0, 1'b0); put(0, 8'hC1, 1'b0); put(0, 8'hC2, 1'b1);
        put(3, 8'hD0, 1'b1);
        s_en[0] = 1'b1; s_en[3] = 1'b1;
        drive_srcs();
        wait_tx(1, 50);
        s_en[0] = 1'b0;
        drive_srcs();
        repeat (50) step();
        chk("stall_no_issue", tx_log_d.size(), 32'd1);
        chk("stall_lock_held", {28'd0, grant}, 32'h1);
        chk("stall_no_timeout", {31'd0, timeout}, 32'd0);
        s_en[0] = 1'b1;
        drive_srcs();
        wait_done(4, 400);
        exp_d[0] = 8'hC0; exp_d[1] = 8'hC1; exp_d[2] = 8'hC2; exp_d[3] = 8'hD0;
        for (int i = 0; i < 4; i++)
            chk("stall_order", {24'd0, tx_log_d[i]}, {24'd0, exp_d[i]});
`endif

        // Reset in BUSY: clears asynchronously, ptr back to 0
        do_reset();
        put(1, 8'hE0, 1'b1);
        s_en[1] = 1'b1;
        drive_srcs();
        wait_done(1, 100);
        tx_log_d.delete(); tx_log_g.delete(); g_log.delete();
        put(3, 8'hF0, 1'b0); put(3, 8'hF1, 1'b1);
        put(0, 8'h60, 1'b1);
        s_en[0] = 1'b1; s_en[3] = 1'b1;
        drive_srcs();
        wait_tx(1, 50);
        chk("midrst_owner_before", {28'd0, tx_log_g[0]}, 32'h8);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_grant", {28'd0, grant}, 32'd0);
        chk("midrst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("midrst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("midrst_timeout", {31'd0, timeout}, 32'd0);
        step(); step();
        clear_models();
        put(3, 8'hF0, 1'b1);
        put(0, 8'h60, 1'b1);
        s_en[0] = 1'b1; s_en[3] = 1'b1;
        rst_n = 1'b1;
        drive_srcs();
        step();
        chk("midrst_rr_restart", {28'd0, grant}, 32'h1);
        wait_done(2, 200);

`ifdef UART_ARB_TIMEOUT_EN
        // Timeout: owner goes silent, lock dropped after 20 stalled cycles
        do_reset();
        put(0, 8'h70, 1'b0); put(0, 8'h71, 1'b1);
        put(1, 8'h80, 1'b1);
        s_en[0] = 1'b1; s_en[1] = 1'b1;
        drive_srcs();
        wait_tx(1, 50);
        s_en[0] = 1'b0;
        drive_srcs();
        k = 0;
        while (timeout !== 1'b1 && k < 100) begin step(); k++; end
        chk("to_delay", k, 32'd21);
        chk("to_release", {28'd0, grant}, 32'd0);
        step();
        chk("to_pulse_width", {31'd0, timeout}, 32'd0);
        chk("to_next_grant", {28'd0, grant}, 32'h2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Message-level round-robin arbiter that lets up to N requesters share one `uart_tx` transmitter. Each requester streams a byte message terminated by a `last` flag. The arbiter locks the UART to one requester for the whole message, so lines never interleave. It sits between application blocks (fortune engine, status reporter, debug echo, etc.) and the single `uart_tx` instance, and drives that instance's `data`/`valid`/`ready` handshake.

## Interface
- `N`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 1_000_000: idle-stall limit while locked. Used only with `UART_ARB_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in N: requester i has byte `req_data[8*i+:8]` available.
- `req_data` in 8*N: packed request bytes.
- `req_last` in N: the offered byte is the final byte of its message.
- `req_ready` out N: registered, one-hot or zero; a byte transfers when `req_valid[i] & req_ready[i]`.
- `grant` out N: one-hot owner of the lock, zero when unlocked.
- `tx_data` out 8: byte to `uart_tx.data`.
- `tx_valid` out 1: one-cycle start pulse to `uart_tx.valid`.
- `tx_ready` in 1: `uart_tx.ready`; high when idle, low while shifting.
- `timeout` out 1: one-cycle pulse when a lock is forcibly released.

## Operation
- States:
  - `IDLE`: no lock. If any `req_valid` is high, pick a winner round-robin starting at `ptr`, set `grant`, set `req_ready[winner]`, and go to `ACCEPT`.
  - `ACCEPT`: on `req_valid[g]`, latch `tx_data`, latch `last_q = req_last[g]`, clear `req_ready`, and go to `ISSUE`.
  - `ISSUE`: when `tx_ready` is high, pulse `tx_valid` for one cycle and go to `BUSY`.
  - `BUSY`: when `tx_ready` is low (UART has started), act on `last_q`:
    - `last_q` = 1: release. Clear `grant`, set `ptr = g+1 mod N`, go to `IDLE`.
    - `last_q` = 0: set `req_ready[g]` and go to `ACCEPT`.
- Round-robin: `ptr` resets to 0. The search order is `ptr`, `ptr+1`, … mod N, and the first asserted `req_valid` wins. A releasing requester therefore gets lowest priority next.
- Lock rules:
  - Non-granted requesters see `req_ready` = 0 throughout a message.
  - Their `req_valid` is ignored until release.
  - A requester dropping `req_valid` mid-message does not release the lock; it simply stalls in `ACCEPT`.
- A single-byte message has `req_last` = 1 on its first byte.
- `tx_data` holds its value from latch until the next accept.
- Reset mid-message: all state clears immediately. A byte already inside `uart_tx` is not recalled; that is `uart_tx`'s own reset.

## Timing
- Reset values:
  - `req_ready`, `grant`, `tx_valid`, `timeout` = 0.
  - `tx_data` = 8'h00.
  - state = `IDLE`, `ptr` = 0.
- Latency with `req_valid` already high and the UART idle:
  - request to `req_ready`: 1 cycle.
  - transfer to `tx_valid`: 2 cycles (ACCEPT→ISSUE, ISSUE→pulse).
- Per byte: `BUSY` waits for `tx_ready` to fall before reaccepting. This guarantees at most one outstanding byte and never double-issues.
- Back-to-back messages from different requesters: one `IDLE` cycle between the release and the next grant.
- `req_valid` and `req_last` are sampled only on the transfer cycle.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter runs while in `ACCEPT` with `req_valid[g]` = 0, and clears on any transfer.
  - On reaching `TIMEOUT_CYCLES`, the arbiter releases the lock exactly as on `last` (ptr advances), pulses `timeout` for 1 cycle, and returns to `IDLE`.
- Undefined: no counter. `timeout` is tied to 0, and the lock is held indefinitely until `last`.

## Structure
- Package `uart_arb_pkg`:
  - state enum `arb_state_t` (`IDLE`, `ACCEPT`, `ISSUE`, `BUSY`).
  - `UART_ARB_MAX_N` = 8.
- Sub-module `rr_pick`: combinational; inputs `req[N]` and `ptr`; outputs a one-hot `win` and `any`. Instantiated once.
- Top module holds the FSM, the latches, `ptr`, and the optional timeout counter.

## Test plan
- Single requester:
  - Stimulus: requester 2 sends "Hi\n" (48,69,0A, last on 0A) with a UART model whose ready stays low 10 cycles after each valid.
  - Required: `tx_valid` pulses exactly 3 times with data 48,69,0A; `grant` = 4'b0100 throughout, then 0.
- Contention:
  - Stimulus: requesters 0 and 1 both assert at reset release, each with a 2-byte message.
  - Required: 0's bytes are fully sent first, then 1's; there is no interleaving.
- Fairness:
  - Stimulus: all 4 requesters are continuously valid with 1-byte messages.
  - Required: grant order is 0,1,2,3,0,1.
- Stall:
  - Stimulus: the granted requester drops `req_valid` for 50 cycles mid-message, while requester 3 stays valid.
  - Required: no byte from 3 is issued until the owner's `last` byte is sent.
- Reset mid-message:
  - Stimulus: assert `rst_n` = 0 in `BUSY`.
  - Required: all outputs go to 0 the same cycle, asynchronously; after release, requester 0 wins first.
- Timeout (`UART_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 20):
  - Stimulus: the owner goes silent.
  - Required: `timeout` pulses after 20 idle cycles, and the next waiting requester is granted 1 cycle later.
